mul_div_iter: RTL and testbench

//  Parametrised iterative multiply/divide unit for the EX stage; replaces the single-mode

---
 rtl/mul_div_iter_pkg.sv | 42 ++++
 rtl/mul_div_iter_div_step.sv | 36 +++
 rtl/mul_div_iter.sv | 249 ++++++++++++++++++++++++
 tb/tb_mul_div_iter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_iter_pkg.sv
// ---------------------------------------------------------------------------
// mul_div_iter_pkg
//   Shared definitions for the iterative multiply/divide unit. The decode stage
//   uses the same op encodings, so every consumer of the MD op field should
//   import this package.
//   Contents:
//     MD_WIDTH_DEFAULT     default operand width
//     MD_MUL_STEP_DEFAULT  default multiplier bits retired per CALC cycle
//     mdOp_e               MULTU / MULT / DIVU / DIV encodings
//     mdState_e            sequencer states
//     mdIsDiv/mdIsSigned   op classification helpers
// ---------------------------------------------------------------------------
package mul_div_iter_pkg;

   localparam int MD_WIDTH_DEFAULT    = 32;
   localparam int MD_MUL_STEP_DEFAULT = 2;

   typedef enum logic [1:0] {
      MD_MULTU = 2'b00,
      MD_MULT  = 2'b01,
      MD_DIVU  = 2'b10,
      MD_DIV   = 2'b11
   } mdOp_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_PREP = 2'b01,
      ST_CALC = 2'b10,
      ST_FIX  = 2'b11
   } mdState_e;

   // True for DIVU and DIV.
   function automatic logic mdIsDiv(input mdOp_e op);
      return (op == MD_DIVU) || (op == MD_DIV);
   endfunction

   // True for the two's complement variants (MULT, DIV).
   function automatic logic mdIsSigned(input mdOp_e op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/mul_div_iter_div_step.sv
// ---------------------------------------------------------------------------
// mul_div_iter_div_step
//   One combinational restoring-division step. The partial remainder is
//   shifted left by one with the next dividend bit appended; if the divisor
//   fits, it is subtracted and the quotient bit is 1.
//   Ports:
//     rem_i      partial remainder from the previous step (always < divisor)
//     bit_i      next dividend bit, MSB first
//     divisor_i  divisor magnitude (never zero when this result is used)
//     rem_o      next partial remainder
//     qBit_o     quotient bit produced by this step
// ---------------------------------------------------------------------------
module mul_div_iter_div_step
   import mul_div_iter_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH_DEFAULT
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             qBit_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] divisorExt;

   assign shifted    = {rem_i, bit_i};
   assign divisorExt = {1'b0, divisor_i};

   // The shifted remainder is below twice the divisor, so whichever value is
   // kept fits back into WIDTH bits and the top bit can be dropped.
   assign qBit_o = (shifted >= divisorExt);
   assign rem_o  = WIDTH'(qBit_o ? (shifted - divisorExt) : shifted);

endmodule

// File: rtl/mul_div_iter.sv
// ---------------------------------------------------------------------------
// mul_div_iter
//   Iterative multiply/divide unit for the EX stage. Runs MULTU/MULT/DIVU/DIV
//   on WIDTH-bit operands and produces HI/LO.
//   Sequence: IDLE -start-> PREP -> CALC (N iterations) -> FIX (done cycle).
//   The sign fix-up and the HI/LO write happen on the edge that enters FIX, so
//   FIX is the done_o cycle; it is also ready, so a new op can start there.
//   Ports:
//     clk, rst        rising-edge clock, synchronous active-high reset
//     start_i         launch an op (accepted only while ready_o)
//     op_i            00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//     a_i, b_i        multiplicand/dividend, multiplier/divisor
//     cancel_i        flush an op in flight without touching results
//     ready_o/busy_o  idle indication and its complement
//     done_o          one-cycle pulse, results valid from this cycle
//     hi_o, lo_o      MUL: upper/lower product; DIV: remainder/quotient
//     div_zero_o      last completed op was a divide by zero
// ---------------------------------------------------------------------------
module mul_div_iter
   import mul_div_iter_pkg::*;
#(
   parameter int WIDTH    = MD_WIDTH_DEFAULT,
   parameter int MUL_STEP = MD_MUL_STEP_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cancel_i,
   output logic             ready_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             div_zero_o
);

   localparam int CNT_W     = $clog2(WIDTH) + 1;
   localparam int MUL_ITERS = WIDTH / MUL_STEP;
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_ITERS - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(WIDTH - 1);

   mdState_e         state_q,    state_d;
   mdOp_e            opSel_q,    opSel_d;
   logic [WIDTH-1:0] aRaw_q,     aRaw_d;
   logic [WIDTH-1:0] bRaw_q,     bRaw_d;
   logic [WIDTH-1:0] accHi_q,    accHi_d;
   logic [WIDTH-1:0] accLo_q,    accLo_d;
   logic [WIDTH-1:0] operand_q,  operand_d;
   logic             negProd_q,  negProd_d;
   logic             negRem_q,   negRem_d;
   logic [CNT_W-1:0] iterCnt_q,  iterCnt_d;
   logic [WIDTH-1:0] hi_q,       hi_d;
   logic [WIDTH-1:0] lo_q,       lo_d;
   logic             divZero_q,  divZero_d;

   logic                      signA;
   logic                      signB;
   logic [WIDTH-1:0]          absA;
   logic [WIDTH-1:0]          absB;
   logic                      accept;
   logic [WIDTH+MUL_STEP-1:0] mcandExt;
   logic [WIDTH+MUL_STEP-1:0] mulPartial;
   logic [WIDTH+MUL_STEP-1:0] mulSum;
   logic [WIDTH-1:0]          mulHiNext;
   logic [WIDTH-1:0]          mulLoNext;
   logic [WIDTH-1:0]          divRemNext;
   logic                      divQBit;
   logic [WIDTH-1:0]          divLoNext;
   logic [WIDTH-1:0]          stepHi;
   logic [WIDTH-1:0]          stepLo;
   logic [2*WIDTH-1:0]        prodRaw;
   logic [2*WIDTH-1:0]        prodFix;
   logic [WIDTH-1:0]          fixHi;
   logic [WIDTH-1:0]          fixLo;

   // Handshake outputs come straight from the state; the done cycle (FIX)
   // already counts as idle so back-to-back ops lose no cycle.
   assign ready_o    = (state_q == ST_IDLE) || (state_q == ST_FIX);
   assign busy_o     = ~ready_o;
   assign done_o     = (state_q == ST_FIX);
   assign hi_o       = hi_q;
   assign lo_o       = lo_q;
   assign div_zero_o = divZero_q;

   // A cancel in the same cycle as a start always wins.
   assign accept = ready_o & start_i & ~cancel_i;

   // Operand magnitudes for PREP. The negation of MIN wraps to MIN, which
   // read as unsigned is exactly |MIN|, so no extra bit is needed.
   assign signA = mdIsSigned(opSel_q) & aRaw_q[WIDTH-1];
   assign signB = mdIsSigned(opSel_q) & bRaw_q[WIDTH-1];
   assign absA  = signA ? -aRaw_q : aRaw_q;
   assign absB  = signB ? -bRaw_q : bRaw_q;

   // Shift-add multiply step: the low MUL_STEP multiplier bits select shifted
   // copies of the multiplicand, added to the running upper half. The sum is
   // one MUL_STEP wider than HI and that overflow shifts into LO together with
   // the multiplier bits still waiting to be consumed.
   always_comb begin
      mcandExt   = {{MUL_STEP{1'b0}}, operand_q};
      mulPartial = '0;
      for (int i = 0; i < MUL_STEP; i++) begin
         if (accLo_q[i]) begin
            mulPartial = mulPartial + (mcandExt << i);
         end
      end
      mulSum    = {{MUL_STEP{1'b0}}, accHi_q} + mulPartial;
      mulHiNext = mulSum[WIDTH+MUL_STEP-1:MUL_STEP];
      mulLoNext = {mulSum[MUL_STEP-1:0], accLo_q[WIDTH-1:MUL_STEP]};
   end

   // Restoring divide: HI holds the partial remainder, LO shifts the dividend
   // out of its top while quotient bits shift in at the bottom.
   mul_div_iter_div_step #(
      .WIDTH     (WIDTH)
   ) u_divStep (
      .rem_i     (accHi_q),
      .bit_i     (accLo_q[WIDTH-1]),
      .divisor_i (operand_q),
      .rem_o     (divRemNext),
      .qBit_o    (divQBit)
   );

   assign divLoNext = {accLo_q[WIDTH-2:0], divQBit};

   // Result of the current CALC iteration plus its signed fix-up. The fix-up
   // is only consumed on the final iteration, when the result is committed.
   always_comb begin
      stepHi  = mdIsDiv(opSel_q) ? divRemNext : mulHiNext;
      stepLo  = mdIsDiv(opSel_q) ? divLoNext  : mulLoNext;
      prodRaw = {stepHi, stepLo};
      prodFix = negProd_q ? -prodRaw : prodRaw;
      if (mdIsDiv(opSel_q)) begin
         fixHi = negRem_q  ? -stepHi : stepHi;
         fixLo = negProd_q ? -stepLo : stepLo;
      end else begin
         fixHi = prodFix[2*WIDTH-1:WIDTH];
         fixLo = prodFix[WIDTH-1:0];
      end
   end

   // Next-state logic. Results (hi/lo/divZero) are only ever written on the
   // edge into FIX, so a cancel anywhere before that leaves them untouched.
   always_comb begin
      state_d   = state_q;
      opSel_d   = opSel_q;
      aRaw_d    = aRaw_q;
      bRaw_d    = bRaw_q;
      accHi_d   = accHi_q;
      accLo_d   = accLo_q;
      operand_d = operand_q;
      negProd_d = negProd_q;
      negRem_d  = negRem_q;
      iterCnt_d = iterCnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      divZero_d = divZero_q;

      unique case (state_q)
         ST_IDLE, ST_FIX: begin
            if (accept) begin
               opSel_d = mdOp_e'(op_i);
               aRaw_d  = a_i;
               bRaw_d  = b_i;
               state_d = ST_PREP;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_PREP: begin
            if (cancel_i) begin
               state_d = ST_IDLE;
            end else if (mdIsDiv(opSel_q) && (bRaw_q == '0)) begin
               hi_d      = aRaw_q;
               lo_d      = '1;
               divZero_d = 1'b1;
               state_d   = ST_FIX;
            end else begin
               accHi_d   = '0;
               accLo_d   = absA;
               operand_d = absB;
               negProd_d = signA ^ signB;
               negRem_d  = signA;
               iterCnt_d = mdIsDiv(opSel_q) ? DIV_LOAD : MUL_LOAD;
               state_d   = ST_CALC;
            end
         end

         ST_CALC: begin
            if (cancel_i) begin
               state_d = ST_IDLE;
            end else begin
               accHi_d = stepHi;
               accLo_d = stepLo;
               if (iterCnt_q == '0) begin
                  hi_d      = fixHi;
                  lo_d      = fixLo;
                  divZero_d = 1'b0;
                  state_d   = ST_FIX;
               end else begin
                  iterCnt_d = iterCnt_q - CNT_W'(1);
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         opSel_q   <= MD_MULTU;
         aRaw_q    <= '0;
         bRaw_q    <= '0;
         accHi_q   <= '0;
         accLo_q   <= '0;
         operand_q <= '0;
         negProd_q <= 1'b0;
         negRem_q  <= 1'b0;
         iterCnt_q <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         divZero_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         opSel_q   <= opSel_d;
         aRaw_q    <= aRaw_d;
         bRaw_q    <= bRaw_d;
         accHi_q   <= accHi_d;
         accLo_q   <= accLo_d;
         operand_q <= operand_d;
         negProd_q <= negProd_d;
         negRem_q  <= negRem_d;
         iterCnt_q <= iterCnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         divZero_q <= divZero_d;
      end
   end

endmodule

// File: tb/tb_mul_div_iter.sv
// ---------------------------------------------------------------------------
// tb_mul_div_iter
//   Directed scoreboard bench for mul_div_iter (WIDTH=32, MUL_STEP=2).
//   Stimulus pushes the hand-computed result and latency of every launched op;
//   a monitor pops and compares whenever done_o is seen.
// ---------------------------------------------------------------------------
module tb_mul_div_iter;
   import mul_div_iter_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic [1:0]  op_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        cancel_i;
   logic        ready_o;
   logic        busy_o;
   logic        done_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic        div_zero_o;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          startCyc;
      int          lat;
      int          id;
   } expect_t;

   expect_t scoreQ[$];
   int      errors = 0;
   int      checks = 0;
   int      cyc    = 0;
   int      opId   = 0;

   localparam int LAT_MUL = 18;
   localparam int LAT_DIV = 34;
   localparam int LAT_DZ  = 2;

   mul_div_iter #(
      .WIDTH      (32),
      .MUL_STEP   (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .op_i       (op_i),
      .a_i        (a_i),
      .b_i        (b_i),
      .cancel_i   (cancel_i),
      .ready_o    (ready_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .hi_o       (hi_o),
      .lo_o       (lo_o),
      .div_zero_o (div_zero_o)
   );

   always #5 clk = ~clk;

   // Cycle index: the value seen after a rising edge names that cycle.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
      end
   endtask

   // Monitor: every done_o must match the oldest outstanding expectation.
   always @(negedge clk) begin : monitor
      expect_t e;
      if (!rst && done_o) begin
         if (scoreQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL spurious_done: got done_o=1 at cycle %0d required no done", cyc);
         end else begin
            e = scoreQ.pop_front();
            checkOutput($sformatf("op%0d_hi", e.id), 64'(hi_o), 64'(e.hi));
            checkOutput($sformatf("op%0d_lo", e.id), 64'(lo_o), 64'(e.lo));
            checkOutput($sformatf("op%0d_divzero", e.id), 64'(div_zero_o), 64'(e.dz));
            checkOutput($sformatf("op%0d_latency", e.id), 64'(cyc - e.startCyc), 64'(e.lat));
            checkOutput($sformatf("op%0d_ready_in_done", e.id), 64'(ready_o), 64'(1));
         end
      end
   end

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_ready"},   64'(ready_o),    64'(1));
      checkOutput({tag, "_busy"},    64'(busy_o),     64'(0));
      checkOutput({tag, "_done"},    64'(done_o),     64'(0));
      checkOutput({tag, "_hi"},      64'(hi_o),       64'(0));
      checkOutput({tag, "_lo"},      64'(lo_o),       64'(0));
      checkOutput({tag, "_divzero"}, 64'(div_zero_o), 64'(0));
   endtask

   // Called #1 after a rising edge; returns in the same phase.
   task automatic waitReady();
      for (int i = 0; i < 200 && !ready_o; i++) begin
         @(posedge clk);
         #1;
      end
      checkOutput("ready_wait", 64'(ready_o), 64'(1));
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 400 && scoreQ.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      checkOutput("queue_drained", 64'(scoreQ.size()), 64'(0));
      scoreQ.delete();
   endtask

   task automatic applyStimulus(input mdOp_e op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] expHi,
                                input logic [31:0] expLo, input logic expDz,
                                input int lat);
      expect_t e;
      waitReady();
      start_i = 1'b1;
      op_i    = op;
      a_i     = a;
      b_i     = b;
      opId++;
      e.hi = expHi; e.lo = expLo; e.dz = expDz;
      e.startCyc = cyc; e.lat = lat; e.id = opId;
      scoreQ.push_back(e);
      @(posedge clk);
      #1;
      start_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int c0;
      expect_t e;
      rst      = 1'b1;
      start_i  = 1'b0;
      cancel_i = 1'b0;
      op_i     = 2'b00;
      a_i      = '0;
      b_i      = '0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      checkResetOutputs("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Multiplies: unsigned max, mixed signs, MIN*MIN.
      applyStimulus(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, LAT_MUL);
      applyStimulus(MD_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, LAT_MUL);
      applyStimulus(MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, LAT_MUL);
      // Signed divides: negative dividend, MIN/-1 wrap, negative divisor.
      applyStimulus(MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, LAT_DIV);
      applyStimulus(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, LAT_DIV);
      applyStimulus(MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, LAT_DIV);
      // Divide by zero, cleared by the next completed op.
      applyStimulus(MD_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1, LAT_DZ);
      applyStimulus(MD_MULTU, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006, 1'b0, LAT_MUL);
      applyStimulus(MD_DIV,   32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1, LAT_DZ);
      applyStimulus(MD_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, LAT_DIV);
      waitDrain();

      // Cancel a DIVU mid-CALC: no done, ready next cycle, results held.
      waitReady();
      start_i = 1'b1;
      op_i    = MD_DIVU;
      a_i     = 32'h00000064;
      b_i     = 32'h00000007;
      c0      = cyc;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("cancel_at_cycle5", 64'(cyc - c0), 64'(5));
      cancel_i = 1'b1;
      @(posedge clk);
      #1;
      cancel_i = 1'b0;
      checkOutput("cancel_ready",   64'(ready_o),    64'(1));
      checkOutput("cancel_busy",    64'(busy_o),     64'(0));
      checkOutput("cancel_hi_held", 64'(hi_o),       64'(32'h00000002));
      checkOutput("cancel_lo_held", 64'(lo_o),       64'(32'h0000000E));
      checkOutput("cancel_dz_held", 64'(div_zero_o), 64'(0));
      applyStimulus(MD_MULTU, 32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A, 1'b0, LAT_MUL);
      waitDrain();

      // start_i held high across two ops: the second is taken in the done cycle.
      waitReady();
      start_i = 1'b1;
      op_i    = MD_MULTU;
      a_i     = 32'h00000003;
      b_i     = 32'h00000005;
      c0      = cyc;
      opId++;
      e.hi = 32'h0; e.lo = 32'h0000000F; e.dz = 1'b0;
      e.startCyc = c0; e.lat = LAT_MUL; e.id = opId;
      scoreQ.push_back(e);
      opId++;
      e.hi = 32'h0; e.lo = 32'h00000051; e.dz = 1'b0;
      e.startCyc = c0 + LAT_MUL; e.lat = LAT_MUL; e.id = opId;
      scoreQ.push_back(e);
      @(posedge clk);
      #1;
      a_i = 32'h00000009;
      b_i = 32'h00000009;
      repeat (LAT_MUL) @(posedge clk);
      #1;
      start_i = 1'b0;
      waitDrain();

      // Reset in the middle of a DIV: everything back to reset values.
      waitReady();
      start_i = 1'b1;
      op_i    = MD_DIVU;
      a_i     = 32'd1000;
      b_i     = 32'd3;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkResetOutputs("midreset");
      repeat (40) @(posedge clk);
      #1;
      waitDrain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
